// File: rtl/watch_set_ctrl_pkg.sv
// Watch set-control shared definitions: FSM states, field indices
// and a counter sizing helper.
package watch_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_PRESS  = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    typedef enum int {
        FLD_SEC  = 0,
        FLD_MIN  = 1,
        FLD_HOUR = 2
    } field_e;

    function automatic int cnt_width(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/watch_set_ctrl_key_repeat.sv
// One key: rising-edge detect plus hold-delay / auto-repeat timing.
// The top grants a press; fire is the delayed or repeated strobe.
module watch_set_ctrl_key_repeat #(
    parameter int DLY  = 50,
    parameter int RATE = 10,
    parameter int CW   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    input  logic tick,
    input  logic grant,
    input  logic abort,
    output logic rise,
    output logic fire,
    output logic held
);

    logic          prev;
    logic          active;
    logic          rep;
    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;

    assign rise  = key & ~prev;
    assign held  = active;
    assign limit = rep ? CW'(RATE) : CW'(DLY);
    assign fire  = active & key & tick & ~abort
                 & ((cnt + CW'(1)) == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= 1'b0;
            active <= 1'b0;
            rep    <= 1'b0;
            cnt    <= '0;
        end else begin
            prev <= key;
            if (abort || !key) begin
                active <= 1'b0;
                rep    <= 1'b0;
                cnt    <= '0;
            end else if (active) begin
                if (fire) begin
                    rep <= 1'b1;
                    cnt <= '0;
                end else if (tick) begin
                    cnt <= cnt + CW'(1);
                end
            end else if (grant && rise) begin
                active <= 1'b1;
                rep    <= 1'b0;
                cnt    <= '0;
            end
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch time-set controller: edit mode, field select, key auto-repeat,
// inactivity timeout and selected-field blink.
module watch_set_ctrl
    import watch_set_ctrl_pkg::*;
#(
    parameter int NUM_FIELDS  = 3,
    parameter int START_FIELD = FLD_SEC,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10,
    parameter int TIMEOUT     = 500,
    parameter int BLINK_HALF  = 25
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_tick,
    input  logic                          i_edit,
    input  logic                          i_up,
    input  logic                          i_down,
    input  logic                          i_right,
    input  logic                          i_left,
    output logic                          o_edit,
    output logic [$clog2(NUM_FIELDS)-1:0] o_field,
    output logic [NUM_FIELDS-1:0]         o_inc,
    output logic [NUM_FIELDS-1:0]         o_dec,
    output logic                          o_blink
);

    localparam int FW = $clog2(NUM_FIELDS);
    localparam int CW = cnt_width(REPEAT_DLY, REPEAT_RATE,
                                  TIMEOUT, BLINK_HALF);
    localparam logic [FW-1:0] F_START = FW'(START_FIELD);
    localparam logic [FW-1:0] F_LAST  = FW'(NUM_FIELDS - 1);

    state_t                state;
    state_t                state_nx;
    logic [FW-1:0]         field_nx;
    logic [NUM_FIELDS-1:0] inc_nx;
    logic [NUM_FIELDS-1:0] dec_nx;
    logic [NUM_FIELDS-1:0] sel;
    logic                  blink_nx;
    logic [CW-1:0]         tcnt;
    logic [CW-1:0]         tcnt_nx;
    logic [CW-1:0]         bcnt;
    logic [CW-1:0]         bcnt_nx;
    logic                  b_wrap;
    logic                  t_end;
    logic                  up_rise, up_fire, up_held;
    logic                  dn_rise, dn_fire, dn_held;
    logic                  grant_up, grant_dn;
    logic                  nav, act, key_on;

    assign sel      = NUM_FIELDS'(1) << o_field;
    assign grant_up = (state == ST_EDIT) & ~i_edit;
    assign grant_dn = grant_up & ~up_rise;
    assign nav      = i_right | i_left;
    assign act      = up_rise | dn_rise | nav;
    assign key_on   = (up_held & i_up) | (dn_held & i_down);
    assign b_wrap   = (bcnt + CW'(1)) == CW'(BLINK_HALF);
    assign t_end    = (tcnt + CW'(1)) == CW'(TIMEOUT);

    watch_set_ctrl_key_repeat #(
        .DLY  (REPEAT_DLY),
        .RATE (REPEAT_RATE),
        .CW   (CW)
    ) u_up (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (i_up),
        .tick  (i_tick),
        .grant (grant_up),
        .abort (i_edit),
        .rise  (up_rise),
        .fire  (up_fire),
        .held  (up_held)
    );

    watch_set_ctrl_key_repeat #(
        .DLY  (REPEAT_DLY),
        .RATE (REPEAT_RATE),
        .CW   (CW)
    ) u_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (i_down),
        .tick  (i_tick),
        .grant (grant_dn),
        .abort (i_edit),
        .rise  (dn_rise),
        .fire  (dn_fire),
        .held  (dn_held)
    );

    always_comb begin
        state_nx = state;
        field_nx = o_field;
        inc_nx   = '0;
        dec_nx   = '0;
        blink_nx = o_blink;
        tcnt_nx  = tcnt;
        bcnt_nx  = bcnt;
        unique case (state)
            ST_IDLE: begin
                if (i_edit) begin
                    state_nx = ST_EDIT;
                    field_nx = F_START;
                    tcnt_nx  = '0;
                    bcnt_nx  = '0;
                    blink_nx = 1'b0;
                end
            end
            ST_EDIT: begin
                if (i_edit) begin
                    state_nx = ST_IDLE;
                end else begin
                    if (up_rise) begin
                        inc_nx   = sel;
                        state_nx = ST_PRESS;
                    end else if (dn_rise) begin
                        dec_nx   = sel;
                        state_nx = ST_PRESS;
                    end
                    if (i_right) begin
                        field_nx = (o_field == F_LAST) ? '0
                                 : o_field + FW'(1);
                    end else if (i_left) begin
                        field_nx = (o_field == '0) ? F_LAST
                                 : o_field - FW'(1);
                    end
                    if (act) begin
                        tcnt_nx  = '0;
                        bcnt_nx  = '0;
                        blink_nx = 1'b0;
                    end else if (i_tick) begin
                        if (t_end) state_nx = ST_IDLE;
                        tcnt_nx  = tcnt + CW'(1);
                        bcnt_nx  = b_wrap ? '0 : bcnt + CW'(1);
                        blink_nx = b_wrap ? ~o_blink : o_blink;
                    end
                end
            end
            ST_PRESS, ST_REPEAT: begin
                // user is active: inactivity timer stays cleared
                tcnt_nx = '0;
                if (i_edit) begin
                    state_nx = ST_IDLE;
                end else if (!key_on) begin
                    state_nx = ST_EDIT;
                end else if (up_fire || dn_fire) begin
                    inc_nx   = up_fire ? sel : '0;
                    dec_nx   = dn_fire ? sel : '0;
                    state_nx = ST_REPEAT;
                    bcnt_nx  = '0;
                    blink_nx = 1'b0;
                end else if (i_tick) begin
                    bcnt_nx  = b_wrap ? '0 : bcnt + CW'(1);
                    blink_nx = b_wrap ? ~o_blink : o_blink;
                end
            end
        endcase
        if (state_nx == ST_IDLE) begin
            tcnt_nx  = '0;
            bcnt_nx  = '0;
            blink_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            o_edit  <= 1'b0;
            o_field <= F_START;
            o_inc   <= '0;
            o_dec   <= '0;
            o_blink <= 1'b0;
            tcnt    <= '0;
            bcnt    <= '0;
        end else begin
            state   <= state_nx;
            o_edit  <= (state_nx != ST_IDLE);
            o_field <= field_nx;
            o_inc   <= inc_nx;
            o_dec   <= dec_nx;
            o_blink <= blink_nx;
            tcnt    <= tcnt_nx;
            bcnt    <= bcnt_nx;
        end
    end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Testbench for watch_set_ctrl: directed scenarios and random key
// traffic checked every cycle against a behavioural model.
module tb_watch_set_ctrl;

    localparam int NF    = 3;
    localparam int START = 0;
    localparam int DLY   = 4;
    localparam int RATE  = 2;
    localparam int TOUT  = 8;
    localparam int BH    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_tick = 1'b0;
    logic          i_edit = 1'b0;
    logic          i_up = 1'b0;
    logic          i_down = 1'b0;
    logic          i_right = 1'b0;
    logic          i_left = 1'b0;
    logic          o_edit;
    logic [1:0]    o_field;
    logic [NF-1:0] o_inc;
    logic [NF-1:0] o_dec;
    logic          o_blink;

    int n_cmp = 0;
    int n_bad = 0;
    int cnum  = 0;

    // model: mode 0 = not editing, 1 = editing, 2 = holding a key
    int            m_mode;
    int            m_field;
    bit            m_key_up;
    int            m_wait;
    int            m_quiet;
    int            m_bphase;
    bit            m_blink;
    bit            m_pu;
    bit            m_pd;
    logic [NF-1:0] e_inc;
    logic [NF-1:0] e_dec;

    watch_set_ctrl #(
        .NUM_FIELDS  (NF),
        .START_FIELD (START),
        .REPEAT_DLY  (DLY),
        .REPEAT_RATE (RATE),
        .TIMEOUT     (TOUT),
        .BLINK_HALF  (BH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tick  (i_tick),
        .i_edit  (i_edit),
        .i_up    (i_up),
        .i_down  (i_down),
        .i_right (i_right),
        .i_left  (i_left),
        .o_edit  (o_edit),
        .o_field (o_field),
        .o_inc   (o_inc),
        .o_dec   (o_dec),
        .o_blink (o_blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_field  = START;
        m_key_up = 1'b0;
        m_wait   = 0;
        m_quiet  = 0;
        m_bphase = 0;
        m_blink  = 1'b0;
        m_pu     = 1'b0;
        m_pd     = 1'b0;
        e_inc    = '0;
        e_dec    = '0;
    endtask

    task automatic blink_tick();
        m_bphase++;
        if (m_bphase == BH) begin
            m_bphase = 0;
            m_blink  = !m_blink;
        end
    endtask

    task automatic model_step();
        bit up_edge;
        bit dn_edge;
        bit busy;
        bit held;
        up_edge = i_up && !m_pu;
        dn_edge = i_down && !m_pd;
        m_pu    = i_up;
        m_pd    = i_down;
        e_inc   = '0;
        e_dec   = '0;
        busy    = 1'b0;
        if (m_mode == 0) begin
            if (i_edit) begin
                m_mode   = 1;
                m_field  = START;
                m_quiet  = 0;
                m_bphase = 0;
                m_blink  = 1'b0;
            end
        end else if (i_edit) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (up_edge || dn_edge) begin
                if (up_edge) e_inc[m_field] = 1'b1;
                else         e_dec[m_field] = 1'b1;
                m_mode   = 2;
                m_key_up = up_edge;
                m_wait   = DLY;
                busy     = 1'b1;
            end
            if (i_right) begin
                m_field = (m_field + 1) % NF;
                busy    = 1'b1;
            end else if (i_left) begin
                m_field = (m_field + NF - 1) % NF;
                busy    = 1'b1;
            end
            if (busy) begin
                m_quiet  = 0;
                m_bphase = 0;
                m_blink  = 1'b0;
            end else if (i_tick) begin
                m_quiet++;
                if (m_quiet == TOUT) m_mode = 0;
                blink_tick();
            end
        end else begin
            held = m_key_up ? i_up : i_down;
            if (!held) begin
                m_mode  = 1;
                m_quiet = 0;
            end else if (i_tick) begin
                m_wait--;
                if (m_wait == 0) begin
                    if (m_key_up) e_inc[m_field] = 1'b1;
                    else          e_dec[m_field] = 1'b1;
                    m_wait   = RATE;
                    m_bphase = 0;
                    m_blink  = 1'b0;
                end else begin
                    blink_tick();
                end
            end
        end
        if (m_mode == 0) begin
            m_blink  = 1'b0;
            m_bphase = 0;
        end
    endtask

    task automatic clk1();
        i_tick = (cnum % 5 == 4);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        chk("edit",  o_edit,  (m_mode != 0));
        chk("field", o_field, m_field);
        chk("inc",   o_inc,   e_inc);
        chk("dec",   o_dec,   e_dec);
        chk("blink", o_blink, m_blink);
        i_edit  = 1'b0;
        i_right = 1'b0;
        i_left  = 1'b0;
        cnum++;
    endtask

    initial begin
        int n_str;
        int ticks;
        int rise_t;
        int fall_t;
        int exit_t;
        bit pb;
        bit tk;
        int r;

        model_reset();
        repeat (3) clk1();
        chk("rst_edit",  o_edit,  0);
        chk("rst_field", o_field, 0);
        chk("rst_inc",   o_inc,   0);
        chk("rst_blink", o_blink, 0);
        rst_n = 1'b1;

        // keys and navigation ignored outside edit mode
        i_up = 1'b1;
        i_right = 1'b1;
        clk1();
        chk("idle_up_inc", o_inc, 0);
        i_up = 1'b0;
        clk1();
        chk("idle_field", o_field, 0);
        chk("idle_edit",  o_edit,  0);

        i_edit = 1'b1;
        clk1();
        chk("edit_on", o_edit, 1);
        i_up = 1'b1;
        clk1();
        chk("up_inc", o_inc, 3'b001);
        i_up = 1'b0;
        clk1();
        chk("up_once", o_inc, 0);

        i_right = 1'b1; clk1(); chk("nav_r1", o_field, 1);
        i_right = 1'b1; clk1(); chk("nav_r2", o_field, 2);
        i_right = 1'b1; clk1(); chk("nav_r3", o_field, 0);
        i_left  = 1'b1; clk1(); chk("nav_l1", o_field, 2);
        i_left  = 1'b1; clk1(); chk("nav_l2", o_field, 1);

        // hold down for 19 tick periods from a tick-aligned press
        while (cnum % 5 != 0) clk1();
        n_str = 0;
        i_down = 1'b1;
        for (int k = 0; k < 95; k++) begin
            clk1();
            if (o_dec != 0) begin
                n_str++;
                chk("dec_field1", o_dec, 3'b010);
            end
        end
        chk("dec_count", n_str, 9);
        i_down = 1'b0;
        n_str = 0;
        for (int k = 0; k < 20; k++) begin
            clk1();
            if (o_dec != 0 || o_inc != 0) n_str++;
        end
        chk("after_release", n_str, 0);

        i_up = 1'b1;
        i_down = 1'b1;
        clk1();
        chk("both_inc", o_inc, 3'b010);
        chk("both_dec", o_dec, 0);
        repeat (30) clk1();
        i_edit = 1'b1;
        clk1();
        chk("exit_in_repeat", o_edit, 0);
        n_str = 0;
        for (int k = 0; k < 20; k++) begin
            clk1();
            if (o_dec != 0 || o_inc != 0) n_str++;
        end
        chk("no_strobe_idle", n_str, 0);
        i_up = 1'b0;
        i_down = 1'b0;
        repeat (2) clk1();

        // untouched edit mode: blink phases, then timeout
        i_edit = 1'b1;
        clk1();
        chk("enter", o_edit, 1);
        chk("enter_field", o_field, START);
        ticks = 0;
        rise_t = -1;
        fall_t = -1;
        exit_t = -1;
        pb = 1'b0;
        for (int k = 0; k < 60 && exit_t < 0; k++) begin
            tk = (cnum % 5 == 4);
            clk1();
            if (tk) ticks++;
            if (!o_edit) begin
                exit_t = ticks;
            end else begin
                if (o_blink && !pb && rise_t < 0) rise_t = ticks;
                if (!o_blink && pb && fall_t < 0) fall_t = ticks;
            end
            pb = o_blink;
        end
        chk("blink_on_tick",  rise_t, 3);
        chk("blink_off_tick", fall_t, 6);
        chk("timeout_tick",   exit_t, 8);
        chk("idle_blink",     o_blink, 0);

        // reset while auto-repeating
        i_edit = 1'b1;
        clk1();
        i_up = 1'b1;
        clk1();
        chk("rep_first", o_inc, 3'b001);
        repeat (30) clk1();
        chk("pre_rst_edit", o_edit, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_edit",  o_edit,  0);
        chk("arst_field", o_field, START);
        chk("arst_inc",   o_inc,   0);
        chk("arst_dec",   o_dec,   0);
        chk("arst_blink", o_blink, 0);
        model_reset();
        repeat (3) clk1();
        rst_n = 1'b1;
        n_str = 0;
        for (int k = 0; k < 25; k++) begin
            clk1();
            if (o_inc != 0) n_str++;
        end
        chk("no_trailing", n_str, 0);
        i_up = 1'b0;
        clk1();

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 59) == 0) i_edit = 1'b1;
            r = $urandom_range(0, 11);
            if (r == 0)      i_right = 1'b1;
            else if (r == 1) i_left = 1'b1;
            if ($urandom_range(0, 24) == 0) i_up = ~i_up;
            if ($urandom_range(0, 24) == 0) i_down = ~i_down;
            clk1();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
